// File: rtl/frame_tx_scheduler.sv
// Serialises a snapshot of the game state into a byte frame for a UART transmitter.
// Optional build macro CHECKSUM_EN appends an XOR checksum of bytes 1-10 as byte 11.
module frame_tx_scheduler #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    input  logic [3:0]  pl1_score,
    input  logic [3:0]  pl2_score,
    input  logic        flag_point,
    input  logic        end_game,
    input  logic        tx_ready,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        timeout_err
);

`ifdef CHECKSUM_EN
    localparam logic [3:0] LastIdx = 4'd11;
`else
    localparam logic [3:0] LastIdx = 4'd10;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StWaitDone} state_e;

    typedef struct packed {
        logic [11:0] p1x;
        logic [11:0] p1y;
        logic [11:0] bx;
        logic [11:0] by;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        eg;
        logic        fp;
    } snap_t;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    snap_t       snap_q, snap_d;
    logic [7:0]  cur_byte;
`ifdef CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tmo_q   <= '0;
            snap_q  <= '0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            snap_q  <= snap_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Frame content comes only from the shadow copy, so input changes mid-frame are invisible.
    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            4'd0:    cur_byte = HEADER;
            4'd1:    cur_byte = {4'h0, snap_q.p1x[11:8]};
            4'd2:    cur_byte = snap_q.p1x[7:0];
            4'd3:    cur_byte = {4'h0, snap_q.p1y[11:8]};
            4'd4:    cur_byte = snap_q.p1y[7:0];
            4'd5:    cur_byte = {4'h0, snap_q.bx[11:8]};
            4'd6:    cur_byte = snap_q.bx[7:0];
            4'd7:    cur_byte = {4'h0, snap_q.by[11:8]};
            4'd8:    cur_byte = snap_q.by[7:0];
            4'd9:    cur_byte = {snap_q.s1, snap_q.s2};
            4'd10:   cur_byte = {6'b0, snap_q.eg, snap_q.fp};
`ifdef CHECKSUM_EN
            4'd11:   cur_byte = csum_q;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        snap_d      = snap_q;
`ifdef CHECKSUM_EN
        csum_d      = csum_q;
`endif
        tx_start    = 1'b0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_tick) state_d = StLoad;
            end
            StLoad: begin
                snap_d.p1x = pl1_posx;
                snap_d.p1y = pl1_posy;
                snap_d.bx  = ball_posx;
                snap_d.by  = ball_posy;
                snap_d.s1  = pl1_score;
                snap_d.s2  = pl2_score;
                snap_d.eg  = end_game;
                snap_d.fp  = flag_point;
                idx_d      = '0;
`ifdef CHECKSUM_EN
                csum_d     = '0;
`endif
                state_d    = StSend;
            end
            StSend: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tmo_d    = '0;
                    state_d  = StWaitDone;
`ifdef CHECKSUM_EN
                    // Header and the checksum byte itself are excluded from the XOR.
                    if (idx_q != 4'd0 && idx_q != LastIdx) csum_d = csum_q ^ cur_byte;
`endif
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    if (idx_q == LastIdx) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StSend;
                    end
                end else if (tmo_q == TIMEOUT_CYC - 16'd1) begin
                    timeout_err = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign overrun = frame_tick && busy;
    assign tx_data = (state_q == StSend || state_q == StWaitDone) ? cur_byte : 8'h00;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Scoreboard bench for frame_tx_scheduler: expected bytes queued at frame request,
// popped and compared on each tx_start.
module tb_frame_tx_scheduler;

    localparam logic [15:0] Tmo = 16'd64;
`ifdef CHECKSUM_EN
    localparam int FrameLen = 12;
`else
    localparam int FrameLen = 11;
`endif

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
    logic [3:0]  pl1_score, pl2_score;
    logic        flag_point, end_game;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_done_auto, tx_done_man;
    logic [7:0]  tx_data;
    logic        tx_start, busy, frame_done, overrun, timeout_err;

    assign tx_done = tx_done_auto | tx_done_man;

    frame_tx_scheduler #(
        .HEADER      (8'hA5),
        .TIMEOUT_CYC (Tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .pl1_posx    (pl1_posx),
        .pl1_posy    (pl1_posy),
        .ball_posx   (ball_posx),
        .ball_posy   (ball_posy),
        .pl1_score   (pl1_score),
        .pl2_score   (pl2_score),
        .flag_point  (flag_point),
        .end_game    (end_game),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int launches = 0;
    int fd_cnt = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;
    int last_start_cyc = 0;
    int tmo_cyc = 0;
    int tick_cyc = 0;
    logic       resp_en;
    logic       in_flight = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame();
        logic [7:0] b[12];
        logic [7:0] x;
        b[0]  = 8'hA5;
        b[1]  = {4'h0, pl1_posx[11:8]};
        b[2]  = pl1_posx[7:0];
        b[3]  = {4'h0, pl1_posy[11:8]};
        b[4]  = pl1_posy[7:0];
        b[5]  = {4'h0, ball_posx[11:8]};
        b[6]  = ball_posx[7:0];
        b[7]  = {4'h0, ball_posy[11:8]};
        b[8]  = ball_posy[7:0];
        b[9]  = {pl1_score, pl2_score};
        b[10] = {6'b0, end_game, flag_point};
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ b[i];
        b[11] = x;
        for (int i = 0; i < FrameLen; i++) exp_q.push_back(b[i]);
    endfunction

    // Monitor: samples on the falling edge, away from the launch edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            in_flight = 1'b0;
        end else begin
            if (tx_done && in_flight) begin
                check_eq("hold", tx_data, held);
                in_flight = 1'b0;
            end
            if (tx_start) begin
                launches++;
                last_start_cyc = cyc;
                check_eq("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("byte", tx_data, exp_q.pop_front());
                held = tx_data;
                in_flight = 1'b1;
            end
            if (frame_done) begin
                fd_cnt++;
                check_eq("fd_with_done", tx_done, 1);
            end
            if (overrun) ovr_cnt++;
            if (timeout_err) begin
                tmo_cnt++;
                tmo_cyc = cyc;
                in_flight = 1'b0;
            end
        end
    end

    // UART model: tx_done ten cycles after each launch when enabled.
    initial begin
        tx_done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && tx_start && rst) begin
                repeat (10) @(posedge clk);
                #1 tx_done_auto = 1'b1;
                @(posedge clk);
                #1 tx_done_auto = 1'b0;
            end
        end
    end

    task automatic tick_frame();
        push_frame();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        tick_cyc = cyc;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int budget, input string tag);
        int k = 0;
        while (launches < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq(tag, launches >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq(tag, busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_tx_data"}, tx_data, 0);
        check_eq({tag, "_tx_start"}, tx_start, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_overrun"}, overrun, 0);
        check_eq({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        int base, fd0, ovr0, tmo0, k;
        rst = 1'b0;
        frame_tick = 1'b0;
        pl1_posx = '0; pl1_posy = '0; ball_posx = '0; ball_posy = '0;
        pl1_score = '0; pl2_score = '0; flag_point = 1'b0; end_game = 1'b0;
        tx_ready = 1'b1;
        tx_done_man = 1'b0;
        resp_en = 1'b1;

        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b1;
        pl1_posx = 12'h1A3; pl1_posy = 12'h2C0; ball_posx = 12'h200; ball_posy = 12'h064;
        pl1_score = 4'd3; pl2_score = 4'd5; flag_point = 1'b1; end_game = 1'b0;

        // Nominal frame and minimum latency.
        base = launches; fd0 = fd_cnt; ovr0 = ovr_cnt;
        tick_frame();
        wait_launches(base + 1, 10, "hdr_wait");
        check_eq("latency", last_start_cyc - tick_cyc, 2);
        wait_idle(400, "nom_idle");
        check_eq("nom_len", launches - base, FrameLen);
        check_eq("nom_fd", fd_cnt - fd0, 1);
        check_eq("nom_ovr", ovr_cnt - ovr0, 0);
        check_eq("nom_q_empty", exp_q.size(), 0);

        // Inputs change after byte 2; frame keeps its snapshot.
        base = launches; fd0 = fd_cnt;
        tick_frame();
        wait_launches(base + 3, 60, "mid_wait");
        pl1_posx = 12'h3FF; pl1_posy = 12'h111; pl1_score = 4'd9; end_game = 1'b1;
        wait_idle(400, "mid_idle");
        check_eq("mid_len", launches - base, FrameLen);
        check_eq("mid_fd", fd_cnt - fd0, 1);

        // Overrun during byte 4.
        base = launches; fd0 = fd_cnt; ovr0 = ovr_cnt;
        tick_frame();
        wait_launches(base + 5, 100, "ovr_wait");
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        wait_idle(400, "ovr_idle");
        repeat (30) @(posedge clk);
        #1;
        check_eq("ovr_cnt", ovr_cnt - ovr0, 1);
        check_eq("ovr_len", launches - base, FrameLen);
        check_eq("ovr_fd", fd_cnt - fd0, 1);
        check_eq("ovr_no_restart", busy, 0);

        // Manual tx_done: tick coincides with the final tx_done.
        resp_en = 1'b0;
        base = launches; fd0 = fd_cnt; ovr0 = ovr_cnt;
        tick_frame();
        for (int i = 0; i < FrameLen; i++) begin
            wait_launches(base + i + 1, 50, "man_wait");
            repeat (2) @(posedge clk);
            #1 tx_done_man = 1'b1;
            frame_tick = (i == FrameLen - 1);
            if (i == FrameLen - 1) begin
                @(negedge clk);
                check_eq("last_fd", frame_done, 1);
                check_eq("last_ovr", overrun, 1);
            end
            @(posedge clk);
            #1 tx_done_man = 1'b0;
            frame_tick = 1'b0;
        end
        repeat (20) @(posedge clk);
        #1;
        check_eq("last_len", launches - base, FrameLen);
        check_eq("last_busy", busy, 0);
        check_eq("last_ovr_cnt", ovr_cnt - ovr0, 1);
        check_eq("last_fd_cnt", fd_cnt - fd0, 1);

        // Stray tx_done while idle is ignored.
        fd0 = fd_cnt;
        #1 tx_done_man = 1'b1;
        @(posedge clk);
        #1 tx_done_man = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("stray_busy", busy, 0);
        check_eq("stray_fd", fd_cnt - fd0, 0);

        // Backpressure, then timeout on a withheld tx_done.
        tx_ready = 1'b0;
        base = launches; fd0 = fd_cnt; tmo0 = tmo_cnt;
        tick_frame();
        repeat (100) @(posedge clk);
        #1;
        check_eq("bp_no_start", launches - base, 0);
        check_eq("bp_busy", busy, 1);
        tx_ready = 1'b1;
        wait_launches(base + 1, 5, "bp_start");
        k = 0;
        while (tmo_cnt == tmo0 && k < int'(Tmo) + 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("tmo_cnt", tmo_cnt - tmo0, 1);
        check_eq("tmo_latency", tmo_cyc - last_start_cyc, Tmo);
        @(posedge clk);
        #1;
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_fd", fd_cnt - fd0, 0);
        exp_q.delete();
        resp_en = 1'b1;

        // Reset in the middle of a frame.
        base = launches; fd0 = fd_cnt;
        tick_frame();
        wait_launches(base + 7, 200, "rst_wait");
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_outputs_zero("midrst");
        exp_q.delete();
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        check_eq("rst_fd", fd_cnt - fd0, 0);
        base = launches; fd0 = fd_cnt;
        tick_frame();
        wait_launches(base + 1, 10, "post_rst_hdr");
        wait_idle(400, "post_rst_idle");
        check_eq("post_rst_len", launches - base, FrameLen);
        check_eq("post_rst_fd", fd_cnt - fd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_tx_scheduler.md
FRAME_TX_SCHEDULER -- requirements
Module: frame_tx_scheduler

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5: first byte of every frame.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd20000: maximum number of cycles to wait for tx_done after a byte is launched.
REQ-003 SHALL have port clk, input, 1: the 65 MHz pixel clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle frame request (vsync-derived).
REQ-006 SHALL have ports pl1_posx, pl1_posy, ball_posx, ball_posy, input, 12 each: game coordinates.
REQ-007 SHALL have ports pl1_score and pl2_score, input, 4 each: scores.
REQ-008 SHALL have ports flag_point and end_game, input, 1 each: game flags.
REQ-009 SHALL have port tx_ready, input, 1: UART transmitter is idle.
REQ-010 SHALL have port tx_done, input, 1: one-cycle pulse when a byte has finished on the line.
REQ-011 SHALL have port tx_data, output, 8: byte to transmit.
REQ-012 SHALL have port tx_start, output, 1: one-cycle launch strobe.
REQ-013 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse after the last byte's tx_done.
REQ-015 SHALL have port overrun, output, 1: one-cycle pulse when a frame_tick is dropped.
REQ-016 SHALL have port timeout_err, output, 1: one-cycle pulse when a byte wait times out.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SEND, WAIT_DONE.
REQ-018 IDLE: on frame_tick, SHALL go to LOAD.
REQ-019 LOAD: SHALL snapshot all game inputs into shadow registers, clear byte index and checksum, then go to SEND; the frame content is fixed from this point on.
REQ-020 Byte order SHALL be:
- HEADER
- {4'h0,pl1_posx[11:8]}, pl1_posx[7:0]
- {4'h0,pl1_posy[11:8]}, pl1_posy[7:0]
- same two-byte format for ball_posx, then ball_posy
- {pl1_score,pl2_score}
- {6'b0,end_game,flag_point}
This gives 11 bytes, indices 0-10.
REQ-021 SEND: when tx_ready=1, SHALL drive tx_data = the byte at the current index, pulse tx_start for exactly one cycle, and go to WAIT_DONE; while tx_ready=0 it SHALL hold in SEND with tx_start=0.
REQ-022 tx_data SHALL stay stable from the tx_start cycle until the matching tx_done.
REQ-023 WAIT_DONE, on tx_done:
- last index: go to IDLE and pulse frame_done in the same cycle;
- otherwise: increment the index and go to SEND.
REQ-024 Minimum latency: frame_tick at cycle N with tx_ready=1 SHALL give the HEADER tx_start at cycle N+2.
REQ-025 A frame_tick while busy=1 SHALL be dropped and overrun pulsed; a frame in progress SHALL never restart.
REQ-026 frame_tick in the same cycle as the final tx_done SHALL be dropped, with overrun pulsed.
REQ-027 A tx_done outside WAIT_DONE SHALL be ignored.
REQ-028 In WAIT_DONE a cycle counter SHALL run; when it reaches TIMEOUT_CYC without tx_done, the FSM SHALL pulse timeout_err, abort the frame and go to IDLE with no frame_done.

Reset
REQ-029 On rst=0, the block SHALL immediately enter IDLE and clear:
- tx_data=8'h00, tx_start=0, busy=0, frame_done=0, overrun=0, timeout_err=0
- index, checksum, timeout counter and shadow registers to 0
REQ-030 Reset during a frame SHALL abort it with no frame_done; the first frame_tick after release SHALL start a fresh frame from HEADER.

Configuration
REQ-031 With CHECKSUM_EN defined:
- a running XOR SHALL accumulate each byte at indices 1-10 as it is launched;
- that XOR SHALL be sent as byte 11, making a 12-byte frame;
- frame_done SHALL follow byte 11's tx_done.
REQ-032 Without CHECKSUM_EN, the checksum logic SHALL be absent and the frame SHALL be 11 bytes.

Verification
REQ-033 Nominal frame, CHECKSUM_EN defined, tx_ready=1, tx_done pulsed 10 cycles after each tx_start:
- inputs: pl1 (0x1A3,0x2C0), ball (0x200,0x064), scores 3/5, flag_point=1, end_game=0
- required bytes: A5 01 A3 02 C0 02 00 00 64 35 01 32
- frame_done after the 12th tx_done.
REQ-034 Same stimulus without CHECKSUM_EN -> 11 bytes ending 35 01; frame_done after the 11th tx_done.
REQ-035 Input change mid-frame: change pl1_posx to 0x3FF after byte 2 -> bytes 1-2 stay 01 A3 and no later byte changes.
REQ-036 Overrun: frame_tick during byte 4 -> overrun pulses once, the frame completes normally, no second frame starts.
REQ-037 Backpressure and timeout:
- hold tx_ready=0 for 100 cycles in SEND -> no tx_start until tx_ready rises;
- withhold tx_done -> timeout_err pulses at TIMEOUT_CYC, busy falls, no frame_done.
REQ-038 Reset mid-frame: assert rst=0 at byte 6 -> all outputs 0 immediately; next frame_tick -> HEADER A5 first.
